fir_out_decimator: RTL and testbench

FIR_OUT_DECIMATOR -- requirements
Module: fir_out_decimator

---
 rtl/fir_out_decimator_if.sv | 23 ++
 rtl/fir_out_decimator.sv | 79 +++++++
 tb/tb_fir_out_decimator.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_out_decimator_if.sv
// fir_out_decimator_if: sample-in / decimated-out handshake bundle with status
interface fir_out_decimator_if #(
   parameter int DEPTH = 4
);
   localparam int LW = $clog2(DEPTH) + 1;
   logic          in_valid;
   logic [15:0]   in_sample;
   logic          in_ready;
   logic          phase_clr;
   logic          out_valid;
   logic          out_ready;
   logic [15:0]   out_sample;
   logic [LW-1:0] level;
   logic          ovf_sticky;
   modport master (
      output in_valid, in_sample, phase_clr, out_ready,
      input  in_ready, out_valid, out_sample, level, ovf_sticky
   );
   modport slave (
      input  in_valid, in_sample, phase_clr, out_ready,
      output in_ready, out_valid, out_sample, level, ovf_sticky
   );
endinterface

// File: rtl/fir_out_decimator.sv
// fir_out_decimator: keeps every DECIM-th accepted sample and queues it in a small FIFO
module fir_out_decimator #(
   parameter int DECIM = 4,
   parameter int DEPTH = 4
) (
   input logic                clk,
   input logic                rst,
   fir_out_decimator_if.slave s
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [PW-1:0] PMAX  = PW'(DECIM - 1);
   localparam logic [LW-1:0] LFULL = LW'(DEPTH);

   logic [15:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   logic [PW-1:0] r_phase;
   logic          r_live;
   logic          r_ovf;
   logic          w_full;
   logic          w_in_ready;
   logic          w_acc;
   logic          w_keep;
   logic          w_out_valid;
   logic          w_pop;
   logic [PW-1:0] w_phase_eff;
   logic [PW-1:0] w_phase_nxt;

   // handshake decode; in_ready depends only on registers, never on out_ready
   always_comb begin
      w_full      = r_level == LFULL;
      w_in_ready  = r_live & ~w_full;
      w_acc       = s.in_valid & w_in_ready;
      w_phase_eff = s.phase_clr ? '0 : r_phase;
      w_keep      = w_acc & (w_phase_eff == '0);
      w_phase_nxt = w_acc ? ((w_phase_eff == PMAX) ? '0 : w_phase_eff + PW'(1)) : w_phase_eff;
      w_out_valid = r_level != '0;
      w_pop       = w_out_valid & s.out_ready;
   end

   // decimation phase, post-reset enable and sticky overflow flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_phase <= '0;
         r_live  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_phase <= w_phase_nxt;
         r_live  <= 1'b1;
         if (w_full & s.in_valid & (w_phase_eff == '0)) r_ovf <= 1'b1;
      end
   end

   // circular FIFO; head is read straight from storage so a write shows up one edge later
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_keep) begin
            r_mem[r_wr_ptr] <= s.in_sample;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_level <= r_level + LW'(w_keep) - LW'(w_pop);
      end
   end

   assign s.in_ready   = w_in_ready;
   assign s.out_valid  = w_out_valid;
   assign s.out_sample = r_mem[r_rd_ptr];
   assign s.level      = r_level;
   assign s.ovf_sticky = r_ovf;
endmodule

// File: tb/tb_fir_out_decimator.sv
// tb_fir_out_decimator: scoreboard bench for three decimation ratios
module tb_fir_out_decimator;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [15:0] q4[$];
   logic [15:0] q1[$];
   logic [15:0] q2[$];
   logic        hold_v [3] = '{1'b0, 1'b0, 1'b0};
   logic [15:0] hold_d [3] = '{16'h0, 16'h0, 16'h0};

   always #5 clk = ~clk;

   fir_out_decimator_if #(.DEPTH(4)) b4 ();
   fir_out_decimator_if #(.DEPTH(4)) b1 ();
   fir_out_decimator_if #(.DEPTH(4)) b2 ();

   fir_out_decimator #(.DECIM(4), .DEPTH(4)) u4 (.clk(clk), .rst(rst), .s(b4));
   fir_out_decimator #(.DECIM(1), .DEPTH(4)) u1 (.clk(clk), .rst(rst), .s(b1));
   fir_out_decimator #(.DECIM(2), .DEPTH(4)) u2 (.clk(clk), .rst(rst), .s(b2));

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic mon(input int k, input logic v, input logic r, input logic [15:0] d);
      logic [15:0] e;
      int sz;
      if (!rst) begin
         hold_v[k] = 1'b0;
         return;
      end
      if (hold_v[k]) begin
         chk($sformatf("hold_valid%0d", k), int'(v), 1);
         chk($sformatf("hold_data%0d", k), int'(d), int'(hold_d[k]));
      end
      hold_v[k] = v & ~r;
      hold_d[k] = d;
      if (v & r) begin
         sz = (k == 0) ? q4.size() : (k == 1) ? q1.size() : q2.size();
         if (sz == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_out%0d: got %0h expected none", k, d);
         end else begin
            case (k)
               0:       e = q4.pop_front();
               1:       e = q1.pop_front();
               default: e = q2.pop_front();
            endcase
            chk($sformatf("out_data%0d", k), int'(d), int'(e));
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      b4.in_valid = 0; b4.in_sample = 0; b4.phase_clr = 0; b4.out_ready = 0;
      b1.in_valid = 0; b1.in_sample = 0; b1.phase_clr = 0; b1.out_ready = 0;
      b2.in_valid = 0; b2.in_sample = 0; b2.phase_clr = 0; b2.out_ready = 0;
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] v33 [5] = '{16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF, 16'h1234};
      int s34 [7] = '{10, 11, 12, 13, 14, 15, 16};
      int n;
      int ph;
      int d;
      fork
         forever begin
            @(negedge clk);
            mon(0, b4.out_valid, b4.out_ready, b4.out_sample);
            mon(1, b1.out_valid, b1.out_ready, b1.out_sample);
            mon(2, b2.out_valid, b2.out_ready, b2.out_sample);
         end
      join_none
      idle();
      // reset state
      repeat (3) tick();
      @(negedge clk);
      chk("rst_in_ready", int'(b4.in_ready), 0);
      chk("rst_out_valid", int'(b4.out_valid), 0);
      chk("rst_level", int'(b4.level), 0);
      chk("rst_ovf", int'(b4.ovf_sticky), 0);
      chk("rst_out_sample", int'(b4.out_sample), 0);
      chk("rst_in_ready_d1", int'(b1.in_ready), 0);
      tick();
      rst = 1'b1;
      tick();
      @(negedge clk);
      chk("rdy_after_rst4", int'(b4.in_ready), 1);
      chk("rdy_after_rst1", int'(b1.in_ready), 1);
      chk("rdy_after_rst2", int'(b2.in_ready), 1);
      tick();
      // DECIM=4 streaming 0..15 with out_ready high
      b4.out_ready = 1;
      for (int i = 0; i <= 16; i++) begin
         b4.in_valid  = (i < 16);
         b4.in_sample = 16'(i);
         if (i < 16 && i % 4 == 0) q4.push_back(16'(i));
         @(negedge clk);
         chk("stream_level_le1", int'(b4.level <= 1), 1);
         if (i > 0 && (i - 1) % 4 == 0) begin
            chk("stream_lat_valid", int'(b4.out_valid), 1);
            chk("stream_lat_data", int'(b4.out_sample), i - 1);
         end
         tick();
      end
      // phase realignment
      for (int i = 0; i < 7; i++) begin
         b4.in_valid  = 1;
         b4.in_sample = 16'(s34[i]);
         b4.phase_clr = (i == 2);
         if (i == 0 || i == 2 || i == 6) q4.push_back(16'(s34[i]));
         tick();
      end
      b4.in_valid  = 0;
      b4.phase_clr = 0;
      repeat (3) tick();
      @(negedge clk);
      chk("phase_clr_drain", q4.size(), 0);
      tick();
      // DECIM=1 overflow on a full FIFO
      for (int i = 0; i < 4; i++) begin
         b1.in_valid  = 1;
         b1.in_sample = v33[i];
         q1.push_back(v33[i]);
         tick();
      end
      b1.in_sample = v33[4];
      q1.push_back(v33[4]);
      @(negedge clk);
      chk("full_level", int'(b1.level), 4);
      chk("full_in_ready", int'(b1.in_ready), 0);
      chk("ovf_before", int'(b1.ovf_sticky), 0);
      tick();
      @(negedge clk);
      chk("ovf_set", int'(b1.ovf_sticky), 1);
      chk("ovf_level", int'(b1.level), 4);
      tick();
      b1.out_ready = 1;
      @(negedge clk);
      chk("full_outrdy_no_inrdy", int'(b1.in_ready), 0);
      tick();
      @(negedge clk);
      chk("pop_no_push_level", int'(b1.level), 3);
      chk("pop_no_push_in_ready", int'(b1.in_ready), 1);
      tick();
      b1.in_valid = 0;
      @(negedge clk);
      chk("push_pop_level", int'(b1.level), 3);
      repeat (6) tick();
      @(negedge clk);
      chk("ovf_drain_level", int'(b1.level), 0);
      chk("ovf_drain_queue", q1.size(), 0);
      tick();
      // DECIM=1 pointer wrap over many laps while hovering near full
      b1.out_ready = 0;
      n = 0;
      for (int c = 0; c < 40; c++) begin
         if (c == 5) b1.out_ready = 1;
         b1.in_valid  = 1;
         b1.in_sample = 16'(16'h0100 + n);
         @(negedge clk);
         if (c == 5) begin
            chk("wrap_full_level", int'(b1.level), 4);
            chk("wrap_full_no_rdy", int'(b1.in_ready), 0);
         end
         if (b1.in_ready) begin
            q1.push_back(16'(16'h0100 + n));
            n++;
         end
         tick();
      end
      b1.in_valid = 0;
      for (int c = 0; c < 10 && q1.size() != 0; c++) tick();
      @(negedge clk);
      chk("wrap_accepted_ge12", int'(n >= 12), 1);
      chk("wrap_drain_queue", q1.size(), 0);
      tick();
      // DECIM=2 random handshakes
      ph = 0;
      d  = 0;
      for (int c = 0; c < 2000; c++) begin
         b2.in_valid  = 1'($urandom_range(0, 1));
         b2.out_ready = 1'($urandom_range(0, 1));
         b2.in_sample = 16'(d);
         @(negedge clk);
         if (b2.in_valid && b2.in_ready) begin
            if (ph == 0) q2.push_back(16'(d));
            ph ^= 1;
            d++;
         end
         tick();
      end
      b2.in_valid  = 0;
      b2.out_ready = 1;
      for (int c = 0; c < 10 && q2.size() != 0; c++) tick();
      @(negedge clk);
      chk("rand_drain_queue", q2.size(), 0);
      tick();
      // reset in the middle of operation
      b4.out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         b4.in_valid  = 1;
         b4.phase_clr = 1;
         b4.in_sample = 16'(16'h00A1 + i);
         q4.push_back(16'(16'h00A1 + i));
         tick();
      end
      b4.in_valid  = 0;
      b4.phase_clr = 0;
      @(negedge clk);
      chk("pre_rst_level", int'(b4.level), 3);
      chk("pre_rst_valid", int'(b4.out_valid), 1);
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", int'(b4.out_valid), 0);
      chk("mid_rst_level", int'(b4.level), 0);
      chk("mid_rst_ovf4", int'(b4.ovf_sticky), 0);
      chk("mid_rst_ovf1", int'(b1.ovf_sticky), 0);
      chk("mid_rst_in_ready", int'(b4.in_ready), 0);
      q4.delete();
      tick();
      rst = 1'b1;
      tick();
      b4.in_valid  = 1;
      b4.in_sample = 16'h00AA;
      q4.push_back(16'h00AA);
      tick();
      b4.in_valid = 0;
      @(negedge clk);
      chk("post_rst_valid", int'(b4.out_valid), 1);
      chk("post_rst_data", int'(b4.out_sample), 16'h00AA);
      tick();
      b4.out_ready = 1;
      tick();
      @(negedge clk);
      chk("post_rst_drain", q4.size(), 0);
      chk("post_rst_empty", int'(b4.out_valid), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
